// File: rtl/cpu_pkg.sv
// Shared CPU types and constants: ALU operation encoding, datapath width and
// default register-file size.
package cpu_pkg;

  localparam int unsigned XLEN     = 16;
  localparam int unsigned NUM_REGS = 8;

  typedef enum logic [3:0] {
    NAND = 4'd0,
    AND  = 4'd1,
    NOR  = 4'd2,
    OR   = 4'd3,
    ADD  = 4'd4,
    SUB  = 4'd5,
    XOR  = 4'd6,
    SL   = 4'd7,
    SR   = 4'd8
  } alu_func_e;

endpackage

// File: rtl/regfile.sv
// Architectural register file: two operand read ports, a debug read port and
// one synchronous write port. r0 always reads as zero and ignores writes.
module regfile import cpu_pkg::*; #(
  parameter int unsigned NUM_REGS = cpu_pkg::NUM_REGS,
  parameter int unsigned RA_W     = $clog2(NUM_REGS)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [RA_W-1:0] i_ra1,
  output logic [XLEN-1:0] o_rd1,
  input  logic [RA_W-1:0] i_ra2,
  output logic [XLEN-1:0] o_rd2,
  input  logic [RA_W-1:0] i_dbg_addr,
  output logic [XLEN-1:0] o_dbg_data,
  input  logic            i_wen,
  input  logic [RA_W-1:0] i_waddr,
  input  logic [XLEN-1:0] i_wdata
);

  logic [XLEN-1:0] r_regs [NUM_REGS];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_wen && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rd1      = (i_ra1 == '0)      ? '0 : r_regs[i_ra1];
  assign o_rd2      = (i_ra2 == '0)      ? '0 : r_regs[i_ra2];
  assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];

endmodule

// File: rtl/operand_stage.sv
// Issue/execute stage: accepts decoded ops, reads operands (with bypass from
// the retiring ALU result) into a single-entry execute slot, and writes back.
module operand_stage import cpu_pkg::*; #(
  parameter int unsigned NUM_REGS = cpu_pkg::NUM_REGS,
  parameter int unsigned RA_W     = $clog2(NUM_REGS)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_dec_valid,
  output logic            o_dec_ready,
  input  alu_func_e       i_dec_func,
  input  logic [RA_W-1:0] i_dec_rs1,
  input  logic [RA_W-1:0] i_dec_rs2,
  input  logic            i_dec_use_imm,
  input  logic [XLEN-1:0] i_dec_imm,
  input  logic [RA_W-1:0] i_dec_rd,
  input  logic            i_dec_wen,
  input  logic            i_flush,
  output alu_func_e       o_alu_func,
  output logic [XLEN-1:0] o_alu_a,
  output logic [XLEN-1:0] o_alu_b,
  input  logic [XLEN-1:0] i_alu_out,
  output logic            o_ex_valid,
  input  logic            i_ex_ready,
  output logic            o_wb_en,
  output logic [RA_W-1:0] o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  input  logic [RA_W-1:0] i_dbg_addr,
  output logic [XLEN-1:0] o_dbg_data
);

  logic            r_ex_valid;
  alu_func_e       r_ex_func;
  logic [XLEN-1:0] r_ex_a;
  logic [XLEN-1:0] r_ex_b;
  logic [RA_W-1:0] r_ex_rd;
  logic            r_ex_wen;

  logic            w_retire;
  logic            w_accept;
  logic            w_dec_ready;
  logic            w_wb_en;
  logic [XLEN-1:0] w_rf_rs1;
  logic [XLEN-1:0] w_rf_rs2;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b;

  regfile #(
    .NUM_REGS (NUM_REGS),
    .RA_W     (RA_W)
  ) u_regfile (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_ra1      (i_dec_rs1),
    .o_rd1      (w_rf_rs1),
    .i_ra2      (i_dec_rs2),
    .o_rd2      (w_rf_rs2),
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_data (o_dbg_data),
    .i_wen      (w_wb_en),
    .i_waddr    (r_ex_rd),
    .i_wdata    (i_alu_out)
  );

  // Source select: r0 is zero, a same-cycle write-back wins over the stored value.
  function automatic logic [XLEN-1:0] read_src(input logic [RA_W-1:0] idx,
                                                input logic [XLEN-1:0] rf_val,
                                                input logic            wb_en,
                                                input logic [RA_W-1:0] wb_rd,
                                                input logic [XLEN-1:0] wb_val);
    if (idx == '0) begin
      return '0;
    end else if (wb_en && (wb_rd == idx)) begin
      return wb_val;
    end
    return rf_val;
  endfunction

  always_comb begin
    w_retire    = r_ex_valid & i_ex_ready & ~i_flush;
    // Reset takes precedence over a retiring write.
    w_wb_en     = w_retire & r_ex_wen & (r_ex_rd != '0) & ~i_rst;
    w_dec_ready = (~r_ex_valid | i_ex_ready) & ~i_flush;
    w_accept    = i_dec_valid & w_dec_ready;
    w_op_a      = read_src(i_dec_rs1, w_rf_rs1, w_wb_en, r_ex_rd, i_alu_out);
    w_op_b      = i_dec_use_imm ? i_dec_imm
                                : read_src(i_dec_rs2, w_rf_rs2, w_wb_en, r_ex_rd, i_alu_out);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex_valid <= 1'b0;
      r_ex_func  <= ADD;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
      r_ex_rd    <= '0;
      r_ex_wen   <= 1'b0;
    end else if (i_flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_accept) begin
      r_ex_valid <= 1'b1;
      r_ex_func  <= i_dec_func;
      r_ex_a     <= w_op_a;
      r_ex_b     <= w_op_b;
      r_ex_rd    <= i_dec_rd;
      r_ex_wen   <= i_dec_wen;
    end else if (i_ex_ready) begin
      r_ex_valid <= 1'b0;
    end
  end

  assign o_dec_ready = w_dec_ready;
  assign o_alu_func  = r_ex_func;
  assign o_alu_a     = r_ex_a;
  assign o_alu_b     = r_ex_b;
  assign o_ex_valid  = r_ex_valid;
  assign o_wb_en     = w_wb_en;
  assign o_wb_rd     = r_ex_rd;
  assign o_wb_data   = i_alu_out;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: a vector table walked one cycle per entry
// plus hand sequences for reset and reset-during-retire.
module tb_operand_stage;
  import cpu_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            dec_valid;
  logic            dec_ready;
  alu_func_e       dec_func;
  logic [2:0]      dec_rs1, dec_rs2, dec_rd;
  logic            dec_use_imm, dec_wen, flush;
  logic [15:0]     dec_imm;
  alu_func_e       alu_func;
  logic [15:0]     alu_a, alu_b, alu_out;
  logic            ex_valid, ex_ready;
  logic            wb_en;
  logic [2:0]      wb_rd;
  logic [15:0]     wb_data;
  logic [2:0]      dbg_addr;
  logic [15:0]     dbg_data;
  logic            alu_force;
  logic [15:0]     alu_force_val;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  operand_stage #(.NUM_REGS(8), .RA_W(3)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_dec_valid   (dec_valid),
    .o_dec_ready   (dec_ready),
    .i_dec_func    (dec_func),
    .i_dec_rs1     (dec_rs1),
    .i_dec_rs2     (dec_rs2),
    .i_dec_use_imm (dec_use_imm),
    .i_dec_imm     (dec_imm),
    .i_dec_rd      (dec_rd),
    .i_dec_wen     (dec_wen),
    .i_flush       (flush),
    .o_alu_func    (alu_func),
    .o_alu_a       (alu_a),
    .o_alu_b       (alu_b),
    .i_alu_out     (alu_out),
    .o_ex_valid    (ex_valid),
    .i_ex_ready    (ex_ready),
    .o_wb_en       (wb_en),
    .o_wb_rd       (wb_rd),
    .o_wb_data     (wb_data),
    .i_dbg_addr    (dbg_addr),
    .o_dbg_data    (dbg_data)
  );

  // Reference ALU, optionally overridden to inject a fixed result.
  always_comb begin
    alu_out = '0;
    if (alu_force) begin
      alu_out = alu_force_val;
    end else begin
      case (alu_func)
        NAND:    alu_out = ~(alu_a & alu_b);
        AND:     alu_out = alu_a & alu_b;
        NOR:     alu_out = ~(alu_a | alu_b);
        OR:      alu_out = alu_a | alu_b;
        ADD:     alu_out = alu_a + alu_b;
        SUB:     alu_out = alu_a - alu_b;
        XOR:     alu_out = alu_a ^ alu_b;
        SL:      alu_out = alu_a << alu_b[3:0];
        SR:      alu_out = alu_a >> alu_b[3:0];
        default: alu_out = '0;
      endcase
    end
  end

  typedef struct {
    logic        dv;
    alu_func_e   fn;
    logic [2:0]  rs1, rs2;
    logic        ui;
    logic [15:0] imm;
    logic [2:0]  rd;
    logic        wen, fl, exr;
    logic [2:0]  dbg;
    logic        frc;
    logic [15:0] fval;
    logic        e_rdy, e_val;
    alu_func_e   e_fn;
    logic [15:0] e_a, e_b;
    logic        e_wb;
    logic [2:0]  e_wrd;
    logic [15:0] e_wd, e_dbg;
  } vec_t;

  localparam int NVEC = 17;
  vec_t tbl [NVEC];

  function automatic vec_t mk(
    input logic dv, input alu_func_e fn, input logic [2:0] rs1, input logic [2:0] rs2,
    input logic ui, input logic [15:0] imm, input logic [2:0] rd, input logic wen,
    input logic fl, input logic exr, input logic [2:0] dbg, input logic frc,
    input logic [15:0] fval,
    input logic e_rdy, input logic e_val, input alu_func_e e_fn, input logic [15:0] e_a,
    input logic [15:0] e_b, input logic e_wb, input logic [2:0] e_wrd,
    input logic [15:0] e_wd, input logic [15:0] e_dbg);
    vec_t v;
    v.dv = dv; v.fn = fn; v.rs1 = rs1; v.rs2 = rs2; v.ui = ui; v.imm = imm; v.rd = rd;
    v.wen = wen; v.fl = fl; v.exr = exr; v.dbg = dbg; v.frc = frc; v.fval = fval;
    v.e_rdy = e_rdy; v.e_val = e_val; v.e_fn = e_fn; v.e_a = e_a; v.e_b = e_b;
    v.e_wb = e_wb; v.e_wrd = e_wrd; v.e_wd = e_wd; v.e_dbg = e_dbg;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got 0x%04h, expected 0x%04h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    dec_valid = v.dv;   dec_func = v.fn;  dec_rs1 = v.rs1; dec_rs2 = v.rs2;
    dec_use_imm = v.ui; dec_imm = v.imm;  dec_rd = v.rd;   dec_wen = v.wen;
    flush = v.fl;       ex_ready = v.exr; dbg_addr = v.dbg;
    alu_force = v.frc;  alu_force_val = v.fval;
  endtask

  task automatic check_vec(input vec_t v, input int idx);
    chk("dec_ready", idx, 16'(dec_ready), 16'(v.e_rdy));
    chk("ex_valid",  idx, 16'(ex_valid),  16'(v.e_val));
    chk("alu_func",  idx, 16'(alu_func),  16'(v.e_fn));
    chk("alu_a",     idx, alu_a,          v.e_a);
    chk("alu_b",     idx, alu_b,          v.e_b);
    chk("wb_en",     idx, 16'(wb_en),     16'(v.e_wb));
    chk("wb_rd",     idx, 16'(wb_rd),     16'(v.e_wrd));
    chk("wb_data",   idx, wb_data,        v.e_wd);
    chk("dbg_data",  idx, dbg_data,       v.e_dbg);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //         dv fn   rs1 rs2 ui imm       rd wen fl exr dbg frc fval
    //         | rdy val fn  a         b         wb wrd wd        dbg
    tbl[0]  = mk(1, ADD, 0, 0, 1, 16'h1234, 1, 1, 0, 1, 1, 0, 16'h0,
                 1, 0, ADD, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    tbl[1]  = mk(0, ADD, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 0, 16'h0,
                 1, 1, ADD, 16'h0000, 16'h1234, 1, 1, 16'h1234, 16'h0000);
    tbl[2]  = mk(1, ADD, 0, 0, 1, 16'h0005, 1, 1, 0, 1, 1, 0, 16'h0,
                 1, 0, ADD, 16'h0000, 16'h1234, 0, 1, 16'h1234, 16'h1234);
    tbl[3]  = mk(1, SUB, 1, 1, 0, 16'h0000, 2, 1, 0, 1, 1, 0, 16'h0,
                 1, 1, ADD, 16'h0000, 16'h0005, 1, 1, 16'h0005, 16'h1234);
    tbl[4]  = mk(0, ADD, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 0, 16'h0,
                 1, 1, SUB, 16'h0005, 16'h0005, 1, 2, 16'h0000, 16'h0005);
    tbl[5]  = mk(1, OR,  1, 0, 1, 16'h00FA, 3, 1, 0, 1, 2, 0, 16'h0,
                 1, 0, SUB, 16'h0005, 16'h0005, 0, 2, 16'h0000, 16'h0000);
    tbl[6]  = mk(1, ADD, 3, 0, 1, 16'h0001, 4, 1, 0, 0, 3, 0, 16'h0,
                 0, 1, OR,  16'h0005, 16'h00FA, 0, 3, 16'h00FF, 16'h0000);
    tbl[7]  = tbl[6];
    tbl[8]  = tbl[6];
    tbl[9]  = mk(1, ADD, 3, 0, 1, 16'h0001, 4, 1, 0, 1, 3, 0, 16'h0,
                 1, 1, OR,  16'h0005, 16'h00FA, 1, 3, 16'h00FF, 16'h0000);
    tbl[10] = mk(0, ADD, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 3, 0, 16'h0,
                 1, 1, ADD, 16'h00FF, 16'h0001, 1, 4, 16'h0100, 16'h00FF);
    tbl[11] = mk(1, XOR, 3, 0, 1, 16'h0F0F, 3, 1, 0, 1, 4, 0, 16'h0,
                 1, 0, ADD, 16'h00FF, 16'h0001, 0, 4, 16'h0100, 16'h0100);
    tbl[12] = mk(1, ADD, 1, 0, 1, 16'h0007, 5, 1, 1, 1, 3, 0, 16'h0,
                 0, 1, XOR, 16'h00FF, 16'h0F0F, 0, 3, 16'h0FF0, 16'h00FF);
    tbl[13] = mk(0, ADD, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 5, 0, 16'h0,
                 1, 0, XOR, 16'h00FF, 16'h0F0F, 0, 3, 16'h0FF0, 16'h0000);
    tbl[14] = mk(1, ADD, 0, 0, 1, 16'h0000, 0, 1, 0, 1, 3, 0, 16'h0,
                 1, 0, XOR, 16'h00FF, 16'h0F0F, 0, 3, 16'h0FF0, 16'h00FF);
    tbl[15] = mk(0, ADD, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 1, 16'hBEEF,
                 1, 1, ADD, 16'h0000, 16'h0000, 0, 0, 16'hBEEF, 16'h0000);
    tbl[16] = mk(0, ADD, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h0,
                 1, 0, ADD, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);

    // Reset, then sweep the debug port.
    rst = 1'b1;
    drive(tbl[16]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ex_valid",  -1, 16'(ex_valid),  16'h0);
    chk("rst_alu_func",  -1, 16'(alu_func),  16'(ADD));
    chk("rst_dec_ready", -1, 16'(dec_ready), 16'h1);
    chk("rst_alu_a",     -1, alu_a,          16'h0);
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      dbg_addr = 3'(a);
      #1;
      chk("rst_dbg", a, dbg_data, 16'h0);
    end

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check_vec(tbl[i], i);
    end

    // Reset while a write-back is about to retire: no write, slot dropped.
    @(negedge clk);
    drive(mk(1, ADD, 1, 0, 1, 16'h0003, 6, 1, 0, 1, 6, 0, 16'h0,
             1, 0, ADD, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0));
    @(negedge clk);
    dec_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_ex_valid", 100, 16'(ex_valid), 16'h1);
    chk("mid_alu_a",    100, alu_a,         16'h0005);
    chk("mid_wb_en",    100, 16'(wb_en),    16'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_ex_valid", 101, 16'(ex_valid), 16'h0);
    chk("post_r6",       101, dbg_data,      16'h0);
    dbg_addr = 3'd1;
    #1;
    chk("post_r1",       101, dbg_data,      16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
